// File: rtl/fan_ctrl_pkg.sv
// Shared encodings and constants for the fan speed sequencer.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRamp = 2'd1,
        StRun  = 2'd2
    } fan_state_e;

    localparam logic [1:0] LEVEL_MAX = 2'd3;

    // Timer length in units, indexed by the timer select switch.
    localparam int unsigned TIMER_UNITS [4] = '{0, 1, 3, 5};

    function automatic int unsigned timer_units(input logic [1:0] sel);
        return TIMER_UNITS[sel];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-driven modulo-N counter with synchronous clear and a one-cycle terminal pulse.
module tick_prescaler #(
    parameter int unsigned N = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + 1'b1;
        end
    end

    // Independent of clr_i so the pulse never loops back through the clear logic.
    assign tc_o = en_i && (cnt_q == Last);

endmodule

// File: rtl/fan_speed_sequencer.sv
// Fan level sequencer with optional soft-start ramping and an off-timer countdown.
// Define SOFT_START_EN to enable the RAMP state; otherwise level follows target directly.
module fan_speed_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned TICK_PER_SEC   = 1000,
    parameter int unsigned RAMP_STEP_MS   = 200,
    parameter int unsigned TIMER_UNIT_SEC = 60,
    parameter int unsigned REMAIN_W       = 10
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_tick_1ms,
    input  logic                i_btn_up,
    input  logic                i_btn_down,
    input  logic                i_btn_off,
    input  logic [1:0]          i_timer_sel,
    output logic [1:0]          o_level,
    output logic [1:0]          o_target,
    output logic [3:0]          o_fan_state,
    output logic                o_ramping,
    output logic                o_timer_active,
    output logic [REMAIN_W-1:0] o_remain_sec
);

    fan_state_e          state_q, state_d;
    logic [1:0]          level_q, level_d;
    logic [1:0]          target_q, target_d;
    logic                tmr_active_q, tmr_active_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic [1:0]          sel_q;
    logic [3:0]          fan_state_q;
    logic                ramping_q;

    logic       up, dn;
    logic       ramp_step, sec_tc, sec_clr;
    logic [1:0] ramp_tgt, lvl_cand;

    assign up = i_btn_up & ~i_btn_down;
    assign dn = i_btn_down & ~i_btn_up;

`ifdef SOFT_START_EN
    logic ramp_clr;
    assign ramp_clr = (state_q != StRamp);

    tick_prescaler #(
        .N (RAMP_STEP_MS)
    ) u_ramp_presc (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .en_i   (i_tick_1ms),
        .clr_i  (ramp_clr),
        .tc_o   (ramp_step)
    );
`else
    assign ramp_step = 1'b0;
`endif

    tick_prescaler #(
        .N (TICK_PER_SEC)
    ) u_sec_presc (
        .clk_i  (i_clk),
        .rst_ni (i_reset),
        .en_i   (i_tick_1ms),
        .clr_i  (sec_clr),
        .tc_o   (sec_tc)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        target_d     = target_q;
        tmr_active_d = tmr_active_q;
        remain_d     = remain_q;
        sec_clr      = ~tmr_active_q;
        ramp_tgt     = target_q;
        lvl_cand     = level_q;

        case (state_q)
            StIdle: begin
                if (up) begin
                    target_d = 2'd1;
                    level_d  = 2'd1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (up && target_q != LEVEL_MAX) begin
                    target_d = target_q + 2'd1;
`ifdef SOFT_START_EN
                    state_d  = StRamp;
`else
                    level_d  = target_q + 2'd1;
`endif
                end else if (dn) begin
                    target_d = target_q - 2'd1;
                    level_d  = target_q - 2'd1;
                    if (target_q == 2'd1) state_d = StIdle;
                end
            end
            StRamp: begin
                if (up && target_q != LEVEL_MAX) ramp_tgt = target_q + 2'd1;
                else if (dn)                     ramp_tgt = target_q - 2'd1;
                lvl_cand = ramp_step ? level_q + 2'd1 : level_q;
                // A step and a lowered target both resolve to the smaller of the two.
                target_d = ramp_tgt;
                level_d  = (lvl_cand < ramp_tgt) ? lvl_cand : ramp_tgt;
                if (ramp_tgt == 2'd0)             state_d = StIdle;
                else if (level_d == ramp_tgt)     state_d = StRun;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            tmr_active_d = 1'b0;
            remain_d     = '0;
        end else if (state_q == StIdle || i_timer_sel != sel_q) begin
            sec_clr      = 1'b1;
            tmr_active_d = (i_timer_sel != 2'b00);
            remain_d     = REMAIN_W'(timer_units(i_timer_sel) * TIMER_UNIT_SEC);
        end else if (tmr_active_q && sec_tc) begin
            if (remain_q == REMAIN_W'(1)) begin
                state_d      = StIdle;
                level_d      = 2'd0;
                target_d     = 2'd0;
                tmr_active_d = 1'b0;
                remain_d     = '0;
            end else begin
                remain_d = remain_q - REMAIN_W'(1);
            end
        end

        if (i_btn_off) begin
            state_d      = StIdle;
            level_d      = 2'd0;
            target_d     = 2'd0;
            tmr_active_d = 1'b0;
            remain_d     = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            level_q      <= 2'd0;
            target_q     <= 2'd0;
            tmr_active_q <= 1'b0;
            remain_q     <= '0;
            sel_q        <= 2'b00;
            fan_state_q  <= 4'b0001;
            ramping_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            target_q     <= target_d;
            tmr_active_q <= tmr_active_d;
            remain_q     <= remain_d;
            sel_q        <= i_timer_sel;
            fan_state_q  <= 4'b0001 << level_d;
            ramping_q    <= (state_d == StRamp);
        end
    end

    assign o_level        = level_q;
    assign o_target       = target_q;
    assign o_fan_state    = fan_state_q;
    assign o_ramping      = ramping_q;
    assign o_timer_active = tmr_active_q;
    assign o_remain_sec   = remain_q;

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Self-checking bench for fan_speed_sequencer: abstract model compared every cycle plus literal pins.
module tb_fan_speed_sequencer;

    localparam int unsigned TPS  = 10;
    localparam int unsigned RSTP = 4;
    localparam int unsigned UNIT = 2;
    localparam int unsigned RW   = 10;
`ifdef SOFT_START_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_tick_1ms = 1'b0;
    logic          i_btn_up = 1'b0;
    logic          i_btn_down = 1'b0;
    logic          i_btn_off = 1'b0;
    logic [1:0]    i_timer_sel = 2'b00;
    logic [1:0]    o_level;
    logic [1:0]    o_target;
    logic [3:0]    o_fan_state;
    logic          o_ramping;
    logic          o_timer_active;
    logic [RW-1:0] o_remain_sec;

    fan_speed_sequencer #(
        .TICK_PER_SEC   (TPS),
        .RAMP_STEP_MS   (RSTP),
        .TIMER_UNIT_SEC (UNIT),
        .REMAIN_W       (RW)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_tick_1ms     (i_tick_1ms),
        .i_btn_up       (i_btn_up),
        .i_btn_down     (i_btn_down),
        .i_btn_off      (i_btn_off),
        .i_timer_sel    (i_timer_sel),
        .o_level        (o_level),
        .o_target       (o_target),
        .o_fan_state    (o_fan_state),
        .o_ramping      (o_ramping),
        .o_timer_active (o_timer_active),
        .o_remain_sec   (o_remain_sec)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    bit running = 1'b0;

    // Model: idle == (target 0), ramping == (level below target).
    int   m_level, m_target, m_ramp_ticks, m_sec_ticks, m_remain;
    bit   m_timer_on;
    logic [1:0] m_prev_sel;
    int   units [4] = '{0, 1, 3, 5};

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_clear();
        m_level = 0; m_target = 0; m_ramp_ticks = 0; m_sec_ticks = 0;
        m_remain = 0; m_timer_on = 1'b0;
    endtask

    task automatic model_step();
        bit up, dn, was_idle, was_ramping;
        int step;
        up = i_btn_up && !i_btn_down;
        dn = i_btn_down && !i_btn_up;
        if (i_btn_off) begin
            model_clear();
            m_prev_sel = i_timer_sel;
            return;
        end
        was_idle    = (m_target == 0);
        was_ramping = (m_level < m_target);
        step = 0;
        if (was_idle) begin
            if (up) begin m_target = 1; m_level = 1; end
        end else begin
            if (up && m_target < 3) m_target++;
            else if (dn)            m_target--;
            if (was_ramping) begin
                if (i_tick_1ms) begin
                    m_ramp_ticks++;
                    if (m_ramp_ticks % RSTP == 0) step = 1;
                end
                m_level = (m_level + step < m_target) ? m_level + step : m_target;
            end else if (dn || !SOFT) begin
                m_level = m_target;
            end
        end
        if (m_level >= m_target) m_ramp_ticks = 0;

        if (m_target == 0) begin
            m_timer_on = 1'b0; m_remain = 0;
        end else if (was_idle || i_timer_sel != m_prev_sel) begin
            m_remain = units[i_timer_sel] * UNIT;
            m_timer_on = (i_timer_sel != 2'b00);
            m_sec_ticks = 0;
        end else if (m_timer_on && i_tick_1ms) begin
            m_sec_ticks++;
            if (m_sec_ticks == TPS) begin
                m_sec_ticks = 0;
                m_remain--;
                if (m_remain == 0) model_clear();
            end
        end
        m_prev_sel = i_timer_sel;
    endtask

    always @(negedge i_clk) begin
        if (running && i_reset) begin
            check("level", int'(o_level), m_level);
            check("target", int'(o_target), m_target);
            check("fan_state", int'(o_fan_state), 1 << m_level);
            check("ramping", int'(o_ramping), int'(m_level < m_target));
            check("timer_active", int'(o_timer_active), int'(m_timer_on));
            check("remain_sec", int'(o_remain_sec), m_remain);
        end
    end

    task automatic cycle(input logic u, input logic d, input logic o, input logic t);
        i_btn_up = u; i_btn_down = d; i_btn_off = o; i_tick_1ms = t;
        @(posedge i_clk);
        model_step();
        #1;
        i_btn_up = 1'b0; i_btn_down = 1'b0; i_btn_off = 1'b0; i_tick_1ms = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        i_timer_sel = s;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_level"}, int'(o_level), 0);
        check({tag, "_target"}, int'(o_target), 0);
        check({tag, "_fan_state"}, int'(o_fan_state), 1);
        check({tag, "_ramping"}, int'(o_ramping), 0);
        check({tag, "_timer_active"}, int'(o_timer_active), 0);
        check({tag, "_remain"}, int'(o_remain_sec), 0);
    endtask

    initial begin
        model_clear();
        m_prev_sel = 2'b00;
        #12;
        check_reset_vals("por");
        @(negedge i_clk);
        i_reset = 1'b1;
        running = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Up x3 on consecutive edges, then soft-start steps every 4 ticks.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("up3_target", int'(o_target), 3);
        check("up3_level", int'(o_level), SOFT ? 1 : 3);
        check("up3_ramping", int'(o_ramping), SOFT ? 1 : 0);
        ticks(3);
        check("ramp_3ticks_level", int'(o_level), SOFT ? 1 : 3);
        ticks(1);
        check("ramp_4ticks_level", int'(o_level), SOFT ? 2 : 3);
        ticks(4);
        check("ramp_8ticks_level", int'(o_level), 3);
        check("ramp_done_ramping", int'(o_ramping), 0);
        check("ramp_done_fan_state", int'(o_fan_state), 8);

        // Ramp at level 2 toward 3, then two downs.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("reramp_level", int'(o_level), SOFT ? 2 : 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("down2_level", int'(o_level), 1);
        check("down2_target", int'(o_target), 1);
        check("down2_ramping", int'(o_ramping), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("down_to_idle_target", int'(o_target), 0);

        // Up+down together is a no-op; off beats up.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        check("run2_level", int'(o_level), 2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("updown_level", int'(o_level), 2);
        check("updown_target", int'(o_target), 2);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("offup_target", int'(o_target), 0);
        check("offup_level", int'(o_level), 0);

        // Off-timer: load on IDLE exit, reload on select change, expire to IDLE.
        set_sel(2'b01);
        check("sel_in_idle_active", int'(o_timer_active), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("tmr_load_remain", int'(o_remain_sec), 2);
        check("tmr_load_active", int'(o_timer_active), 1);
        ticks(10);
        check("tmr_10_remain", int'(o_remain_sec), 1);
        set_sel(2'b11);
        check("tmr_reload_remain", int'(o_remain_sec), 10);
        set_sel(2'b01);
        ticks(19);
        check("tmr_19_remain", int'(o_remain_sec), 1);
        ticks(1);
        check("tmr_expire_level", int'(o_level), 0);
        check("tmr_expire_active", int'(o_timer_active), 0);
        check("tmr_expire_target", int'(o_target), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        set_sel(2'b00);
        check("sel_off_active", int'(o_timer_active), 0);
        check("sel_off_remain", int'(o_remain_sec), 0);
        check("sel_off_level", int'(o_level), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle at level 2.
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        check("pre_rst_level", int'(o_level), 2);
        #2;
        i_reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_clear();
        m_prev_sel = 2'b00;
        @(negedge i_clk);
        #1;
        i_reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst_level", int'(o_level), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
